// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and 7-segment constants for the parking barrier controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_IN  = 2'd1,
    GATE_OUT = 2'd2
  } gate_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g..a}; dp stays dark on every digit.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_btn_debounce.sv
// Synchronises a raw active-low button, debounces it and flags each new press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else cnt_d = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier-gate controller: entry/exit sequencing, occupancy count, servo PWM and display.
// state    | meaning
// IDLE     | gate closed, waiting for an entry or exit press
// GATE_IN  | gate open for an arriving car; count +1 when the open timer expires
// GATE_OUT | gate open for a leaving car; count -1 when the open timer expires
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY        = 6,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int PWM_PERIOD      = 1000000,
  parameter int PULSE_CLOSED    = 25000,
  parameter int PULSE_OPEN      = 75000,
  parameter int OPEN_CYCLES     = 150000000,
  localparam int CNT_W          = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_btn_n,
  input  logic             exit_btn_n,
  output logic             servo_pwm,
  output logic             gate_open,
  output logic             full,
  output logic             empty,
  output logic             denied,
  output logic [CNT_W-1:0] occupancy,
  output logic [7:0]       seg_ones,
  output logic [7:0]       seg_tens
);

  localparam int TMR_W = $clog2(OPEN_CYCLES + 1);
  localparam int PWM_W = $clog2(PWM_PERIOD + 1);

  logic entry_level, entry_press, exit_level, exit_press;
  logic entry_evt, exit_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk(clk), .reset(reset), .btn_n(entry_btn_n), .level(entry_level), .press(entry_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk(clk), .reset(reset), .btn_n(exit_btn_n), .level(exit_level), .press(exit_press)
  );

  assign entry_evt = entry_press & ~entry_level;
  assign exit_evt  = exit_press & ~exit_level;

  gate_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic             denied_q, denied_d;
  logic             gate_open_q, gate_open_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] width_q, width_d;
  logic             servo_q, servo_d;
  logic [7:0]       seg_ones_q, seg_ones_d, seg_tens_q, seg_tens_d;
  logic [6:0]       occ_ext;

  assign full  = (occupancy_q == CNT_W'(CAPACITY));
  assign empty = (occupancy_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    occupancy_d = occupancy_q;
    denied_d    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Exit has priority; a refused entry only reaches here when no exit was taken.
        if (exit_evt && !empty) state_d = GATE_OUT;
        else if (entry_evt && !full) state_d = GATE_IN;
        else if (entry_evt) denied_d = 1'b1;
      end
      GATE_IN, GATE_OUT: begin
        if (timer_q == TMR_W'(OPEN_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
          if (state_q == GATE_IN && !full) occupancy_d = occupancy_q + 1'b1;
          if (state_q == GATE_OUT && !empty) occupancy_d = occupancy_q - 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    gate_open_d = (state_d != IDLE);

    // Width is only resampled at frame start so a frame is never cut short.
    pwm_cnt_d = (pwm_cnt_q == PWM_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + 1'b1;
    width_d   = width_q;
    if (pwm_cnt_q == '0) width_d = gate_open_q ? PWM_W'(PULSE_OPEN) : PWM_W'(PULSE_CLOSED);
    servo_d = (pwm_cnt_q < width_d);

    occ_ext    = 7'(occupancy_q);
    seg_ones_d = seg_code(4'(occ_ext % 7'd10));
    seg_tens_d = (occ_ext < 7'd10) ? SEG_BLANK : seg_code(4'(occ_ext / 7'd10));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      occupancy_q <= '0;
      denied_q    <= 1'b0;
      gate_open_q <= 1'b0;
      pwm_cnt_q   <= '0;
      width_q     <= PWM_W'(PULSE_CLOSED);
      servo_q     <= 1'b0;
      seg_ones_q  <= SEG_DIGIT[0];
      seg_tens_q  <= SEG_DIGIT[0];
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      occupancy_q <= occupancy_d;
      denied_q    <= denied_d;
      gate_open_q <= gate_open_d;
      pwm_cnt_q   <= pwm_cnt_d;
      width_q     <= width_d;
      servo_q     <= servo_d;
      seg_ones_q  <= seg_ones_d;
      seg_tens_q  <= seg_tens_d;
    end
  end

  assign servo_pwm = servo_q;
  assign gate_open = gate_open_q;
  assign denied    = denied_q;
  assign occupancy = occupancy_q;
  assign seg_ones  = seg_ones_q;
  assign seg_tens  = seg_tens_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scenario and randomized checks of parking_gate_ctrl against an action-level occupancy model.
module tb_parking_gate_ctrl;

  localparam int CAP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_btn_n, exit_btn_n;
  logic       servo_pwm, gate_open, full, empty, denied;
  logic [1:0] occupancy;
  logic [7:0] seg_ones, seg_tens;

  int errors = 0;
  int checks = 0;
  int model_occ = 0;

  parking_gate_ctrl #(
    .CAPACITY(CAP), .DEBOUNCE_CYCLES(4), .PWM_PERIOD(20),
    .PULSE_CLOSED(2), .PULSE_OPEN(6), .OPEN_CYCLES(40)
  ) dut (
    .clk(clk), .reset(reset), .entry_btn_n(entry_btn_n), .exit_btn_n(exit_btn_n),
    .servo_pwm(servo_pwm), .gate_open(gate_open), .full(full), .empty(empty),
    .denied(denied), .occupancy(occupancy), .seg_ones(seg_ones), .seg_tens(seg_tens)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  default: return 8'h90;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presses the selected buttons, releases each after its hold, and counts gate openings / denied cycles.
  task automatic action(input bit e, input bit x, input int he, input int hx, input int win,
                        output int opens, output int dens);
    bit prev;
    opens = 0;
    dens = 0;
    @(negedge clk);
    prev = gate_open;
    if (e) entry_btn_n = 1'b0;
    if (x) exit_btn_n = 1'b0;
    for (int i = 1; i <= win; i++) begin
      @(negedge clk);
      if (i == he) entry_btn_n = 1'b1;
      if (i == hx) exit_btn_n = 1'b1;
      if (gate_open && !prev) opens++;
      if (denied) dens++;
      prev = gate_open;
    end
    entry_btn_n = 1'b1;
    exit_btn_n = 1'b1;
  endtask

  task automatic test_reset;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b expected 1/0", empty, full); end
    checks++; if (gate_open !== 1'b0 || denied !== 1'b0 || servo_pwm !== 1'b0) begin errors++; $display("FAIL reset_outs: gate=%b denied=%b pwm=%b expected 0", gate_open, denied, servo_pwm); end
    checks++; if (seg_ones !== 8'hC0 || seg_tens !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h/%h expected c0/c0", seg_ones, seg_tens); end
  endtask

  task automatic test_bounce;
    int o, d;
    @(negedge clk);
    entry_btn_n = 1'b0; tick(3);
    entry_btn_n = 1'b1; tick(1);
    entry_btn_n = 1'b0; tick(3);
    entry_btn_n = 1'b1;
    action(1'b0, 1'b0, 0, 0, 20, o, d);
    checks++; if (o !== 0 || occupancy !== 2'd0) begin errors++; $display("FAIL bounce_none: opens=%0d occ=%0d expected 0/0", o, occupancy); end
    action(1'b1, 1'b0, 10, 0, 80, o, d);
    checks++; if (o !== 1) begin errors++; $display("FAIL held_one_open: got %0d expected 1", o); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL held_occ: got %0d expected 1", occupancy); end
    checks++; if (seg_ones !== 8'hF9 || seg_tens !== 8'hFF) begin errors++; $display("FAIL held_seg: got %h/%h expected f9/ff", seg_ones, seg_tens); end
  endtask

  task automatic test_fill;
    int o, d;
    for (int k = 2; k <= 3; k++) begin
      action(1'b1, 1'b0, 8, 0, 80, o, d);
      checks++; if (occupancy !== 2'(k)) begin errors++; $display("FAIL fill_occ: got %0d expected %0d", occupancy, k); end
    end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_full: full=%b empty=%b expected 1/0", full, empty); end
    checks++; if (seg_ones !== 8'hB0) begin errors++; $display("FAIL fill_seg: got %h expected b0", seg_ones); end
    action(1'b1, 1'b0, 8, 0, 80, o, d);
    checks++; if (d !== 1) begin errors++; $display("FAIL denied_width: got %0d cycles expected 1", d); end
    checks++; if (o !== 0 || occupancy !== 2'd3) begin errors++; $display("FAIL denied_state: opens=%0d occ=%0d expected 0/3", o, occupancy); end
  endtask

  task automatic test_empty_exit;
    int o, d;
    for (int k = 2; k >= 0; k--) begin
      action(1'b0, 1'b1, 0, 8, 80, o, d);
      checks++; if (occupancy !== 2'(k) || o !== 1) begin errors++; $display("FAIL drain: occ=%0d opens=%0d expected %0d/1", occupancy, o, k); end
    end
    action(1'b0, 1'b1, 0, 8, 80, o, d);
    checks++; if (o !== 0 || empty !== 1'b1 || d !== 0) begin errors++; $display("FAIL empty_exit: opens=%0d empty=%b denied=%0d expected 0/1/0", o, empty, d); end
    action(1'b1, 1'b0, 8, 0, 80, o, d);
    action(1'b0, 1'b1, 0, 8, 80, o, d);
    checks++; if (occupancy !== 2'd0 || o !== 1) begin errors++; $display("FAIL in_out: occ=%0d opens=%0d expected 0/1", occupancy, o); end
  endtask

  task automatic test_simultaneous;
    int o, d;
    action(1'b1, 1'b0, 8, 0, 80, o, d);
    action(1'b1, 1'b0, 8, 0, 80, o, d);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL simul_setup: got %0d expected 2", occupancy); end
    action(1'b1, 1'b1, 70, 8, 100, o, d);
    checks++; if (o !== 1 || d !== 0) begin errors++; $display("FAIL simul_events: opens=%0d denied=%0d expected 1/0", o, d); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL simul_occ: got %0d expected 1 (exit wins)", occupancy); end
  endtask

  task automatic test_pwm;
    bit s [150];
    int runs [$];
    int rises [$];
    int highs, len, sixes, six_pos, bad;
    highs = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (servo_pwm) highs++; end
    checks++; if (highs !== 4) begin errors++; $display("FAIL pwm_idle: %0d high of 40 expected 4", highs); end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (i == 5) entry_btn_n = 1'b0;
      if (i == 15) entry_btn_n = 1'b1;
      s[i] = servo_pwm;
    end
    for (int i = 1; i < 150; i++) begin
      if (s[i] && !s[i-1]) begin
        len = 0;
        for (int j = i; j < 150 && s[j]; j++) len++;
        if (i + len < 150) begin runs.push_back(len); rises.push_back(i); end
      end
    end
    sixes = 0; six_pos = -1; bad = 0;
    foreach (runs[k]) begin
      if (runs[k] == 6) begin
        sixes++;
        if (six_pos >= 0 && six_pos != k - 1) bad++;
        six_pos = k;
      end else if (runs[k] != 2) bad++;
    end
    for (int k = 1; k < rises.size(); k++) if (rises[k] - rises[k-1] != 20) bad++;
    checks++; if (sixes !== 2) begin errors++; $display("FAIL pwm_open_frames: got %0d wide frames expected 2", sixes); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pwm_shape: %0d irregular frames expected 0", bad); end
    checks++; if (runs.size() == 0 || runs[runs.size()-1] !== 2) begin errors++; $display("FAIL pwm_return: last frame not 2-wide, %0d frames seen", runs.size()); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL pwm_occ: got %0d expected 2", occupancy); end
  endtask

  task automatic test_reset_mid_open;
    int o, d;
    bit seen;
    action(1'b0, 1'b1, 0, 8, 80, o, d);
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL rmo_setup: got %0d expected 1", occupancy); end
    @(negedge clk);
    entry_btn_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); if (gate_open) seen = 1; end
    entry_btn_n = 1'b1;
    checks++; if (!seen) begin errors++; $display("FAIL rmo_open: gate_open not seen within 30 cycles expected 1"); end
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (occupancy !== 2'd0 || gate_open !== 1'b0 || servo_pwm !== 1'b0) begin errors++; $display("FAIL rmo_async: occ=%0d gate=%b pwm=%b expected 0/0/0", occupancy, gate_open, servo_pwm); end
    checks++; if (seg_ones !== 8'hC0) begin errors++; $display("FAIL rmo_seg: got %h expected c0", seg_ones); end
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    action(1'b1, 1'b0, 8, 0, 80, o, d);
    checks++; if (occupancy !== 2'd1 || o !== 1) begin errors++; $display("FAIL rmo_resume: occ=%0d opens=%0d expected 1/1", occupancy, o); end
  endtask

  task automatic test_random;
    int o, d, kind, exp_o, exp_d;
    bit e, x;
    model_occ = 1;
    for (int n = 0; n < 14; n++) begin
      kind = int'($urandom_range(0, 3));
      exp_o = 0; exp_d = 0;
      if (kind == 3) begin
        e = $urandom_range(0, 1) == 1;
        x = !e;
        action(e, x, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 40, o, d);
      end else begin
        e = (kind == 0) || (kind == 2);
        x = (kind == 1) || (kind == 2 && model_occ > 0);
        if (x && model_occ > 0) begin exp_o = 1; model_occ--; end
        else if (e && model_occ < CAP) begin exp_o = 1; model_occ++; end
        else if (e) exp_d = 1;
        action(e, x, int'($urandom_range(6, 20)), int'($urandom_range(6, 20)), 80, o, d);
      end
      checks++; if (o !== exp_o || d !== exp_d) begin errors++; $display("FAIL rand_events[%0d]: opens=%0d denied=%0d expected %0d/%0d", n, o, d, exp_o, exp_d); end
      checks++; if (occupancy !== 2'(model_occ)) begin errors++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", n, occupancy, model_occ); end
      checks++; if (full !== (model_occ == CAP) || empty !== (model_occ == 0)) begin errors++; $display("FAIL rand_flags[%0d]: full=%b empty=%b occ_model=%0d", n, full, empty, model_occ); end
      checks++; if (seg_ones !== seg_of(model_occ) || seg_tens !== 8'hFF) begin errors++; $display("FAIL rand_seg[%0d]: got %h/%h expected %h/ff", n, seg_ones, seg_tens, seg_of(model_occ)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    entry_btn_n = 1'b1;
    exit_btn_n = 1'b1;
    tick(3);
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    test_bounce;
    test_fill;
    test_empty_exit;
    test_simultaneous;
    test_pwm;
    test_reset_mid_open;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
